mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between instruction fetch and the load/store traffic produced by the execute stage. Requests arrive as single-cycle valid pulses. The block queues one request per requester, grants the port round-robin and drives one request at a time to the memory. It waits for the variable-latency completion, then returns the result to the owner as a single-cycle valid pulse.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Each requester has one pending slot; the port is granted round-robin, one access at a time.
module mem_port_arbiter #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_valid,
   output logic [INST_W-1:0] o_if_inst,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   output logic              o_ls_valid,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_mem_cen,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_valid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic              o_ovf
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              if_pend_q, if_pend_d;
   logic [ADDR_W-1:0] if_addr_q, if_addr_d;
   logic              ls_pend_q, ls_pend_d;
   logic              ls_we_q, ls_we_d;
   logic [ADDR_W-1:0] ls_addr_q, ls_addr_d;
   logic [DATA_W-1:0] ls_wdata_q, ls_wdata_d;
   logic              cen_q, cen_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;
   logic              if_valid_q, if_valid_d;
   logic [INST_W-1:0] if_inst_q, if_inst_d;
   logic              ls_valid_q, ls_valid_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              ovf_q, ovf_d;

   logic if_done, ls_done, if_acc, ls_acc, if_eff, ls_eff, grant_ls;

   // A slot stays occupied while its access is in flight; it frees on its own completion.
   assign if_done  = (state_q == S_WAIT) && i_mem_valid && (owner_q == OWN_IF);
   assign ls_done  = (state_q == S_WAIT) && i_mem_valid && (owner_q == OWN_LS);
   assign if_acc   = i_if_req && (!if_pend_q || if_done);
   assign ls_acc   = i_ls_req && (!ls_pend_q || ls_done);
   assign if_eff   = i_if_req || if_pend_q;
   assign ls_eff   = i_ls_req || ls_pend_q;
   assign grant_ls = ls_eff && (!if_eff || (last_q == OWN_IF));

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      if_pend_d  = if_pend_q;
      if_addr_d  = if_addr_q;
      ls_pend_d  = ls_pend_q;
      ls_we_d    = ls_we_q;
      ls_addr_d  = ls_addr_q;
      ls_wdata_d = ls_wdata_q;
      cen_d      = 1'b0;
      wen_d      = wen_q;
      maddr_d    = maddr_q;
      mwdata_d   = mwdata_q;
      if_valid_d = 1'b0;
      if_inst_d  = if_inst_q;
      ls_valid_d = 1'b0;
      ls_rdata_d = ls_rdata_q;
      ovf_d      = ovf_q;

      if (if_acc) begin
         if_pend_d = 1'b1;
         if_addr_d = i_if_addr;
      end else if (if_done) begin
         if_pend_d = 1'b0;
      end

      if (ls_acc) begin
         ls_pend_d  = 1'b1;
         ls_we_d    = i_ls_we;
         ls_addr_d  = i_ls_addr;
         ls_wdata_d = i_ls_wdata;
      end else if (ls_done) begin
         ls_pend_d = 1'b0;
      end

      if ((i_if_req && !if_acc) || (i_ls_req && !ls_acc)) ovf_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            // A same-cycle request is driven straight from the inputs, skipping the slot.
            if (if_eff || ls_eff) begin
               state_d = S_WAIT;
               cen_d   = 1'b1;
               owner_d = grant_ls;
               last_d  = grant_ls;
               if (grant_ls) begin
                  wen_d    = ls_pend_q ? ls_we_q    : i_ls_we;
                  maddr_d  = ls_pend_q ? ls_addr_q  : i_ls_addr;
                  mwdata_d = ls_pend_q ? ls_wdata_q : i_ls_wdata;
               end else begin
                  wen_d    = 1'b0;
                  maddr_d  = if_pend_q ? if_addr_q : i_if_addr;
                  mwdata_d = '0;
               end
            end
         end
         S_WAIT: begin
            if (i_mem_valid) begin
               state_d = S_IDLE;
               if (owner_q == OWN_IF) begin
                  if_valid_d = 1'b1;
                  if_inst_d  = i_mem_rdata[INST_W-1:0];
               end else begin
                  ls_valid_d = 1'b1;
                  if (!wen_q) ls_rdata_d = i_mem_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         last_q     <= OWN_IF;
         owner_q    <= OWN_IF;
         if_pend_q  <= 1'b0;
         if_addr_q  <= '0;
         ls_pend_q  <= 1'b0;
         ls_we_q    <= 1'b0;
         ls_addr_q  <= '0;
         ls_wdata_q <= '0;
         cen_q      <= 1'b0;
         wen_q      <= 1'b0;
         maddr_q    <= '0;
         mwdata_q   <= '0;
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         ls_valid_q <= 1'b0;
         ls_rdata_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         if_pend_q  <= if_pend_d;
         if_addr_q  <= if_addr_d;
         ls_pend_q  <= ls_pend_d;
         ls_we_q    <= ls_we_d;
         ls_addr_q  <= ls_addr_d;
         ls_wdata_q <= ls_wdata_d;
         cen_q      <= cen_d;
         wen_q      <= wen_d;
         maddr_q    <= maddr_d;
         mwdata_q   <= mwdata_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         ls_valid_q <= ls_valid_d;
         ls_rdata_q <= ls_rdata_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_if_valid  = if_valid_q;
   assign o_if_inst   = if_inst_q;
   assign o_ls_valid  = ls_valid_q;
   assign o_ls_rdata  = ls_rdata_q;
   assign o_mem_cen   = cen_q;
   assign o_mem_wen   = wen_q;
   assign o_mem_addr  = maddr_q;
   assign o_mem_wdata = mwdata_q;
   assign o_busy      = (state_q == S_WAIT);
   assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table plus hand-written reset, spurious and tie sequences.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_valid;
   logic [31:0] if_inst;
   logic        ls_req;
   logic        ls_we;
   logic [63:0] ls_addr;
   logic [63:0] ls_wdata;
   logic        ls_valid;
   logic [63:0] ls_rdata;
   logic        mem_cen;
   logic        mem_wen;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_valid;
   logic [63:0] mem_rdata;
   logic        busy;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   mem_port_arbiter #(.ADDR_W(64), .INST_W(32), .DATA_W(64)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_valid(if_valid), .o_if_inst(if_inst),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .o_ls_valid(ls_valid), .o_ls_rdata(ls_rdata),
      .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
      .o_busy(busy), .o_ovf(ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record = inputs for a cycle and the registered outputs seen after that edge.
   typedef struct {
      logic rst, ifr; logic [63:0] ifa;
      logic lsr, we; logic [63:0] lsa, wd;
      logic mv; logic [63:0] mrd;
      logic cen, wen; logic [63:0] addr, wdata;
      logic ifv; logic [31:0] inst;
      logic lsv; logic [63:0] lsrd;
      logic bsy, ov;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r, input logic ifr, input logic [63:0] ifa,
      input logic lsr, input logic we, input logic [63:0] lsa, input logic [63:0] wd,
      input logic mv, input logic [63:0] mrd,
      input logic cen, input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
      input logic ifv, input logic [31:0] inst, input logic lsv, input logic [63:0] lsrd,
      input logic bsy, input logic ov);
      vec_t v;
      v.rst = r; v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.we = we; v.lsa = lsa; v.wd = wd;
      v.mv = mv; v.mrd = mrd; v.cen = cen; v.wen = wen; v.addr = addr; v.wdata = wdata;
      v.ifv = ifv; v.inst = inst; v.lsv = lsv; v.lsrd = lsrd; v.bsy = bsy; v.ov = ov;
      return v;
   endfunction

   // scoreboard helpers
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic r, input logic ifr, input logic [63:0] ifa,
                        input logic lsr, input logic we, input logic [63:0] lsa,
                        input logic [63:0] wd, input logic mv, input logic [63:0] mrd);
      @(negedge clk);
      rst = r; if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = we;
      ls_addr = lsa; ls_wdata = wd; mem_valid = mv; mem_rdata = mrd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
   endtask

   // Every memory issue must match the next expected address, in order.
   always @(negedge clk) begin
      if (mem_cen === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_order: unexpected issue addr %h, expected none", mem_addr);
         end else begin
            chk("issue_order", mem_addr, exp_q.pop_front());
         end
      end
      if (if_valid === 1'b1 || ls_valid === 1'b1)
         chk("valid_exclusive", {63'd0, if_valid & ls_valid}, 64'd0);
   end

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
      ls_addr = 0; ls_wdata = 0; mem_valid = 0; mem_rdata = 0;

      exp_q = '{64'h40, 64'h100, 64'h44, 64'h200, 64'h80, 64'h88,
                64'h300, 64'h500, 64'h100, 64'h44, 64'h108, 64'h48};

      //            rst ifr ifa    lsr we lsa     wd            mv mrd           cen wen addr    wdata         ifv inst          lsv lsrd    bsy ov
      vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,      0,            0, 0,            0, 0,      0, 0));
      // single fetch, L=1
      vecs.push_back(mk(0, 1, 'h40,  0, 0, 0,      0,            0, 0,            1, 0, 'h40,   0,            0, 0,            0, 0,      1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 'h40,   0,            0, 0,            0, 0,      1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            1, 'h00A00093,   0, 0, 'h40,   0,            1, 'h00A00093,   0, 0,      0, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 'h40,   0,            0, 'h00A00093,   0, 0,      0, 0));
      // simultaneous after reset: load first, fetch the cycle after ls_valid
      vecs.push_back(mk(1, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,      0,            0, 0,            0, 0,      0, 0));
      vecs.push_back(mk(0, 1, 'h44,  1, 0, 'h100,  0,            0, 0,            1, 0, 'h100,  0,            0, 0,            0, 0,      1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            1, 'h1111,       0, 0, 'h100,  0,            0, 0,            1, 'h1111, 0, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            1, 0, 'h44,   0,            0, 0,            0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            1, 'h2222,       0, 0, 'h44,   0,            1, 'h2222,       0, 'h1111, 0, 0));
      // store, L=3; rdata left unchanged
      vecs.push_back(mk(0, 0, 0,     1, 1, 'h200,  'hDEADBEEF,   0, 0,            1, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            1, 'h9999,       0, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       1, 'h1111, 0, 0));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 1, 'h200,  'hDEADBEEF,   0, 'h2222,       0, 'h1111, 0, 0));
      // overflow: drop during WAIT, accept in the completion cycle
      vecs.push_back(mk(0, 1, 'h80,  0, 0, 0,      0,            0, 0,            1, 0, 'h80,   0,            0, 'h2222,       0, 'h1111, 1, 0));
      vecs.push_back(mk(0, 1, 'h84,  0, 0, 0,      0,            0, 0,            0, 0, 'h80,   0,            0, 'h2222,       0, 'h1111, 1, 1));
      vecs.push_back(mk(0, 1, 'h88,  0, 0, 0,      0,            1, 'h3333,       0, 0, 'h80,   0,            1, 'h3333,       0, 'h1111, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            1, 0, 'h88,   0,            0, 'h3333,       0, 'h1111, 1, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            1, 'h4444,       0, 0, 'h88,   0,            1, 'h4444,       0, 'h1111, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 'h88,   0,            0, 'h4444,       0, 'h1111, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].lsr, vecs[i].we,
               vecs[i].lsa, vecs[i].wd, vecs[i].mv, vecs[i].mrd);
         step();
         chk($sformatf("row%0d cen", i),      {63'd0, mem_cen},  {63'd0, vecs[i].cen});
         chk($sformatf("row%0d wen", i),      {63'd0, mem_wen},  {63'd0, vecs[i].wen});
         chk($sformatf("row%0d addr", i),     mem_addr,          vecs[i].addr);
         chk($sformatf("row%0d wdata", i),    mem_wdata,         vecs[i].wdata);
         chk($sformatf("row%0d if_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].ifv});
         chk($sformatf("row%0d if_inst", i),  {32'd0, if_inst},  {32'd0, vecs[i].inst});
         chk($sformatf("row%0d ls_valid", i), {63'd0, ls_valid}, {63'd0, vecs[i].lsv});
         chk($sformatf("row%0d ls_rdata", i), ls_rdata,          vecs[i].lsrd);
         chk($sformatf("row%0d busy", i),     {63'd0, busy},     {63'd0, vecs[i].bsy});
         chk($sformatf("row%0d ovf", i),      {63'd0, ovf},      {63'd0, vecs[i].ov});
      end

      // spurious completion while idle
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h1234);
      step();
      chk("spur if_valid", {63'd0, if_valid}, 64'd0);
      chk("spur ls_valid", {63'd0, ls_valid}, 64'd0);
      chk("spur if_inst",  {32'd0, if_inst},  64'h4444);
      chk("spur ls_rdata", ls_rdata,          64'h1111);
      chk("spur busy",     {63'd0, busy},     64'd0);

      // reset mid-transaction, then a late completion
      drive(0, 0, 0, 1, 0, 64'h300, 0, 0, 0);
      step();
      chk("rst_mid issue", {63'd0, mem_cen}, 64'd1);
      idle_step();
      chk("rst_mid busy_before", {63'd0, busy}, 64'd1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("rst_mid addr",  mem_addr,          64'd0);
      chk("rst_mid inst",  {32'd0, if_inst},  64'd0);
      chk("rst_mid rdata", ls_rdata,          64'd0);
      chk("rst_mid busy",  {63'd0, busy},     64'd0);
      chk("rst_mid ovf",   {63'd0, ovf},      64'd0);
      chk("rst_mid cen",   {63'd0, mem_cen},  64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h5555);
      step();
      chk("late_done if_valid", {63'd0, if_valid}, 64'd0);
      chk("late_done ls_valid", {63'd0, ls_valid}, 64'd0);
      chk("late_done rdata",    ls_rdata,          64'd0);
      drive(0, 1, 64'h500, 0, 0, 0, 0, 0, 0);
      step();
      chk("post_rst cen",  {63'd0, mem_cen}, 64'd1);
      chk("post_rst addr", mem_addr,         64'h500);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h6666);
      step();
      chk("post_rst if_valid", {63'd0, if_valid}, 64'd1);
      chk("post_rst if_inst",  {32'd0, if_inst},  64'h6666);

      // round-robin ties built from completion-cycle re-requests
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 64'h44, 1, 0, 64'h100, 0, 0, 0);
      step();
      chk("tie1 ls_first", mem_addr, 64'h100);
      drive(0, 0, 0, 1, 0, 64'h108, 0, 1, 64'hAA);
      step();
      chk("tie1 ls_valid", {63'd0, ls_valid}, 64'd1);
      chk("tie1 ls_rdata", ls_rdata,          64'hAA);
      idle_step();
      chk("tie2 if_wins cen", {63'd0, mem_cen}, 64'd1);
      chk("tie2 if_wins addr", mem_addr,        64'h44);
      drive(0, 1, 64'h48, 0, 0, 0, 0, 1, 64'hBB);
      step();
      chk("tie2 if_inst", {32'd0, if_inst}, 64'hBB);
      idle_step();
      chk("tie3 ls_wins addr", mem_addr,        64'h108);
      chk("tie3 ls_wins cen", {63'd0, mem_cen}, 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'hCC);
      step();
      chk("tie3 ls_rdata", ls_rdata, 64'hCC);
      idle_step();
      chk("tie4 addr", mem_addr, 64'h48);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'hDD);
      step();
      chk("tie4 if_inst", {32'd0, if_inst}, 64'hDD);
      idle_step();
      idle_step();
      chk("issues_remaining", exp_q.size(), 64'd0);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
